// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types, segment constants and decode for the score display
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int MAX_DISPLAY = 9999;
   localparam int BCD_DIGITS  = 4;

   // BCD image of MAX_DISPLAY, loaded on saturation
   localparam logic [15:0] MAX_BCD = {4'(MAX_DISPLAY / 1000), 4'((MAX_DISPLAY / 100) % 10),
                                      4'((MAX_DISPLAY / 10) % 10), 4'(MAX_DISPLAY % 10)};

   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      case (nibble)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/ssd_score_driver_bin2bcd.sv
// rtl/ssd_score_driver_bin2bcd.sv - sequential double-dabble converter with saturation
module bin2bcd_seq
   import ssd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bin_in,
   output logic [15:0] digits,
   output logic        overflow,
   output logic        valid
);

   conv_state_t state, state_next;
   logic [15:0] bin_sr;
   logic [19:0] bcd;
   logic [19:0] bcd_adj;
   logic [4:0]  count;
   logic        saturate;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = SHIFT;
         SHIFT:   if (count == 5'd1) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign saturate = (bcd[19:16] != 4'd0) || (bcd[15:0] > MAX_BCD);

   // digits/overflow move only in DONE so the scan never sees a half-converted value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_sr   <= '0;
         bcd      <= '0;
         count    <= '0;
         digits   <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               bin_sr <= bin_in;
               bcd    <= '0;
               count  <= 5'd16;
            end
            SHIFT: begin
               bcd    <= {bcd_adj[18:0], bin_sr[15]};
               bin_sr <= {bin_sr[14:0], 1'b0};
               count  <= count - 5'd1;
            end
            DONE: begin
               if (saturate) begin
                  digits   <= MAX_BCD;
                  overflow <= 1'b1;
               end else begin
                  digits   <= bcd[15:0];
                  overflow <= 1'b0;
               end
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ssd_score_driver.sv
// rtl/ssd_score_driver.sv - score display: BCD conversion, digit scan, blanking, segment drive
module ssd_score_driver
   import ssd_pkg::*;
#(
   parameter int REFRESH_BITS  = 18,
   parameter bit BLANK_LEADING = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] display_number,
   output logic [3:0]  anode,
   output logic [6:0]  ssd_out,
   output logic        overflow,
   output logic        bcd_valid
);

   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [1:0]              sel;
   logic [15:0]             digits;
   logic [BCD_DIGITS-1:0]   blank;
   logic                    higher_zero;
   logic [3:0]              cur_digit;

   bin2bcd_seq u_conv (
      .clk      (clk),
      .reset    (reset),
      .bin_in   (display_number),
      .digits   (digits),
      .overflow (overflow),
      .valid    (bcd_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) refresh_cnt <= '0;
      else       refresh_cnt <= refresh_cnt + 1'b1;
   end

   assign sel       = refresh_cnt[REFRESH_BITS-1 -: 2];
   assign cur_digit = digits[4*sel +: 4];

   // a digit blanks only if it and every digit above it are zero; digit 0 always shows
   always_comb begin
      blank       = '0;
      higher_zero = 1'b1;
      for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
         higher_zero = higher_zero && (digits[4*k +: 4] == 4'd0);
         blank[k]    = BLANK_LEADING && higher_zero;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode   <= 4'b1111;
         ssd_out <= SEG_BLANK;
      end else if (blank[sel]) begin
         anode   <= 4'b1111;
         ssd_out <= SEG_BLANK;
      end else begin
         anode   <= ~(4'b0001 << sel);
         ssd_out <= seg_decode(cur_digit);
      end
   end

endmodule
